// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   RV32M/RV64M multiply-divide unit that sits beside the execute-stage ALU.
//   Multiply is a fixed-latency pipeline of MUL_STAGES cycles. Divide is an
//   iterative radix-2 restoring divider (1 setup edge, XLEN iterations, one
//   sign fix-up cycle). Divide-by-zero and signed overflow complete in one
//   cycle.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset
//   flush_i       abort the op in flight; blocks acceptance in the same cycle
//   req_valid_i   operation request
//   req_ready_o   unit can accept (IDLE or DONE, and no flush)
//   funct3_i      RV M-extension funct3 (MUL..REMU)
//   rs1_i         operand a / dividend
//   rs2_i         operand b / divisor
//   rd_in_i       destination tag, returned unchanged with the result
//   resp_valid_o  one-cycle result pulse, no backpressure
//   resp_data_o   result, held between pulses
//   resp_rd_o     tag of the completed op, held between pulses
//   busy_o        op in flight (MUL, DIV or FIX)
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_in_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic [4:0]      resp_rd_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN + MUL_STAGES) + 1;
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] DIV_CNT_INIT = CW'(XLEN - 1);
    localparam logic [CW-1:0] MUL_CNT_INIT = (MUL_STAGES >= 2) ? CW'(MUL_STAGES - 2) : '0;
    localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state_q, state_d, accept_state;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_ready;
    logic            accept;

    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [4:0]      resp_rd_q, resp_rd_d;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic            is_div, div_signed, div_zero, div_ovf, div_special;
    logic [XLEN-1:0] div_special_res;

    assign is_div      = funct3_i[2];
    assign div_signed  = ~funct3_i[0];
    assign div_zero    = (rs2_i == '0);
    assign div_ovf     = div_signed && (rs1_i == INT_MIN) && (rs2_i == '1);
    assign div_special = div_zero || div_ovf;
    // funct3[1] selects remainder
    assign div_special_res = funct3_i[1] ? (div_zero ? rs1_i : '0)
                                         : (div_zero ? '1    : rs1_i);

    // -----------------------------------------------------------------------
    // Multiplier: operands sign/zero-extended; low 2*XLEN bits of the product
    // are exact for every signedness combination.
    // -----------------------------------------------------------------------
    logic                   mul_sa, mul_sb;
    logic signed [2*XLEN-1:0] mul_a, mul_b, mul_prod;
    logic [XLEN-1:0]        mul_res, mul_out;

    assign mul_sa   = (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10) && rs1_i[XLEN-1];
    assign mul_sb   = (funct3_i[1:0] == 2'b01) && rs2_i[XLEN-1];
    assign mul_a    = {{XLEN{mul_sa}}, rs1_i};
    assign mul_b    = {{XLEN{mul_sb}}, rs2_i};
    assign mul_prod = mul_a * mul_b;
    assign mul_res  = (funct3_i[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    generate
        if (MUL_STAGES >= 2) begin : g_mul_pipe
            logic [XLEN-1:0] pipe_q [MUL_STAGES-1];
            // Stage boundary: product delay line, one register per extra stage
            always_ff @(posedge clk_i) begin
                pipe_q[0] <= mul_res;
                for (int i = 1; i < MUL_STAGES - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mul_out = pipe_q[MUL_STAGES-2];
        end else begin : g_mul_comb
            assign mul_out = mul_res;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Restoring divider datapath (magnitudes; signs fixed in FIX)
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] quo_q, dvs_q, rem_q, rd_dummy_unused;
    logic            neg_quo_q, neg_rem_q, is_rem_q;
    logic [4:0]      rd_q;
    logic [XLEN:0]   div_shift, div_diff;
    logic [XLEN-1:0] div_fixed;

    assign rd_dummy_unused = '0;
    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};
    assign div_fixed = is_rem_q ? cond_neg(rem_q, neg_rem_q) : cond_neg(quo_q, neg_quo_q);

    always_ff @(posedge clk_i) begin
        if (accept) begin
            quo_q     <= cond_neg(rs1_i, div_signed && rs1_i[XLEN-1]);
            dvs_q     <= cond_neg(rs2_i, div_signed && rs2_i[XLEN-1]);
            rem_q     <= '0;
            neg_quo_q <= div_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            neg_rem_q <= div_signed && rs1_i[XLEN-1];
            is_rem_q  <= funct3_i[1];
            rd_q      <= rd_in_i;
        end else if (state_q == S_DIV) begin
            // Borrow bit clear: divisor fits, keep the difference and shift in 1
            if (!div_diff[XLEN]) begin
                rem_q <= div_diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= div_shift[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        accept_state = S_DONE;
        if (!is_div) begin
            accept_state = (MUL_STAGES == 1) ? S_DONE : S_MUL;
        end else if (!div_special) begin
            accept_state = S_DIV;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = accept_state;
                    cnt_d   = is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            S_DIV: begin
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        req_ready    = (state_q == S_IDLE || state_q == S_DONE) && !flush_i;
        busy_o       = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
        resp_valid_o = (state_q == S_DONE);
    end

    assign req_ready_o = req_ready;
    assign accept      = req_valid_i && req_ready;

    // -----------------------------------------------------------------------
    // Result register: loaded on every entry into DONE, held otherwise
    // -----------------------------------------------------------------------
    always_comb begin
        resp_data_d = resp_data_q;
        resp_rd_d   = resp_rd_q;
        if (state_d == S_DONE) begin
            if (accept) begin
                resp_rd_d   = rd_in_i;
                resp_data_d = is_div ? div_special_res : mul_res;
            end else if (state_q == S_MUL) begin
                resp_rd_d   = rd_q;
                resp_data_d = mul_out;
            end else begin
                resp_rd_d   = rd_q;
                resp_data_d = div_fixed | rd_dummy_unused;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_data_q <= '0;
            resp_rd_q   <= '0;
        end else begin
            resp_data_q <= resp_data_d;
            resp_rd_q   <= resp_rd_d;
        end
    end

    assign resp_data_o = resp_data_q;
    assign resp_rd_o   = resp_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  funct3 = '0;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic [3:0]  rv = '0, fl = '0;
    logic [3:0]  rr, vld, bsy;
    logic [4:0]  rdo0, rdo1, rdo2, rdo3;
    logic [31:0] d0, d1, d2;
    logic [63:0] d3;
    logic [63:0] dout [4];
    logic [4:0]  rdo [4];

    assign dout[0] = {32'b0, d0};
    assign dout[1] = {32'b0, d1};
    assign dout[2] = {32'b0, d2};
    assign dout[3] = d3;
    assign rdo[0] = rdo0;
    assign rdo[1] = rdo1;
    assign rdo[2] = rdo2;
    assign rdo[3] = rdo3;

    muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[0]), .req_valid_i(rv[0]), .req_ready_o(rr[0]),
        .funct3_i(funct3), .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .rd_in_i(rd_in),
        .resp_valid_o(vld[0]), .resp_data_o(d0), .resp_rd_o(rdo0), .busy_o(bsy[0]));
    muldiv_unit #(.XLEN(32), .MUL_STAGES(1)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[1]), .req_valid_i(rv[1]), .req_ready_o(rr[1]),
        .funct3_i(funct3), .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .rd_in_i(rd_in),
        .resp_valid_o(vld[1]), .resp_data_o(d1), .resp_rd_o(rdo1), .busy_o(bsy[1]));
    muldiv_unit #(.XLEN(32), .MUL_STAGES(4)) u2 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[2]), .req_valid_i(rv[2]), .req_ready_o(rr[2]),
        .funct3_i(funct3), .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .rd_in_i(rd_in),
        .resp_valid_o(vld[2]), .resp_data_o(d2), .resp_rd_o(rdo2), .busy_o(bsy[2]));
    muldiv_unit #(.XLEN(64), .MUL_STAGES(2)) u3 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl[3]), .req_valid_i(rv[3]), .req_ready_o(rr[3]),
        .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2), .rd_in_i(rd_in),
        .resp_valid_o(vld[3]), .resp_data_o(d3), .resp_rd_o(rdo3), .busy_o(bsy[3]));

    typedef struct {
        int          k;
        logic [63:0] data;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;
    int   free_at [4] = '{0, 0, 0, 0};

    function automatic int xl_of(input int k);
        return (k == 3) ? 64 : 32;
    endfunction

    function automatic int ms_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 4 : 2;
    endfunction

    // Reference: plain wide signed/unsigned arithmetic, truncated to XLEN.
    function automatic logic [63:0] ref_res(input int xl, input logic [2:0] f,
                                            input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] mask, a, b, res;
        logic signed [129:0] sa, sbv, ua, ub, p, q;
        mask = (xl == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
        a = ai & mask;
        b = bi & mask;
        sa  = (xl == 64) ? {{66{a[63]}}, a} : {{98{a[31]}}, a[31:0]};
        sbv = (xl == 64) ? {{66{b[63]}}, b} : {{98{b[31]}}, b[31:0]};
        ua  = {66'b0, a};
        ub  = {66'b0, b};
        p = '0;
        q = '0;
        case (f)
            3'd0, 3'd1: p = sa * sbv;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            3'd4:       q = sa / sbv;
            3'd5:       q = ua / ub;
            3'd6:       q = sa % sbv;
            default:    q = ua % ub;
        endcase
        if (!f[2]) begin
            if (f == 3'd0) res = p[63:0];
            else           res = (xl == 64) ? p[127:64] : {32'b0, p[63:32]};
        end else if (b == '0) begin
            res = f[1] ? a : mask;
        end else begin
            res = q[63:0];
        end
        return res & mask;
    endfunction

    function automatic int ref_lat(input int xl, input int ms, input logic [2:0] f,
                                   input logic [63:0] ai, input logic [63:0] bi);
        logic [63:0] mask, a, b, mn;
        mask = (xl == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
        a = ai & mask;
        b = bi & mask;
        mn = 64'd1 << (xl - 1);
        if (!f[2]) return ms;
        if (b == '0) return 1;
        if (!f[0] && a == mn && b == mask) return 1;
        return xl + 2;
    endfunction

    task automatic issue(input int k, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input bit push,
                         input bit use_exp, input logic [63:0] expv, output int acc);
        int   exp_acc;
        int   n;
        exp_t e;
        @(negedge clk);
        funct3 = f;
        rs1 = a;
        rs2 = b;
        rd_in = rd;
        rv[k] = 1'b1;
        exp_acc = (cyc > free_at[k]) ? cyc : free_at[k];
        #1;
        n = 0;
        while (!rr[k] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        acc = cyc;
        tests++;
        if (!rr[k] || acc != exp_acc) begin
            fails++;
            $display("FAIL accept_cycle inst=%0d f=%0d: accepted at %0d, required %0d", k, f, acc, exp_acc);
        end
        e.k    = k;
        e.rd   = rd;
        e.data = use_exp ? expv : ref_res(xl_of(k), f, a, b);
        e.due  = acc + ref_lat(xl_of(k), ms_of(k), f, a, b);
        if (push) sb.push_back(e);
        free_at[k] = e.due;
        @(posedge clk);
        #1 rv[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Monitor: every response must match the oldest expectation, on its due cycle
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k]) begin
                    if (sb.size() == 0 || sb[0].k != k) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_resp inst=%0d cyc=%0d: got data %h, required no response", k, cyc, dout[k]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        tests += 3;
                        if (dout[k] !== e.data) begin
                            fails++;
                            $display("FAIL resp_data inst=%0d cyc=%0d: got %h, required %h", k, cyc, dout[k], e.data);
                        end
                        if (rdo[k] !== e.rd) begin
                            fails++;
                            $display("FAIL resp_rd inst=%0d cyc=%0d: got %0d, required %0d", k, cyc, rdo[k], e.rd);
                        end
                        if (cyc != e.due) begin
                            fails++;
                            $display("FAIL resp_cycle inst=%0d: got cycle %0d, required %0d", k, cyc, e.due);
                        end
                    end
                end
            end
            if (sb.size() > 0 && cyc > sb[0].due) begin
                tests++;
                fails++;
                $display("FAIL missing_resp inst=%0d: nothing by cycle %0d, required at %0d", sb[0].k, cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    typedef struct {
        logic [2:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
    } dir_t;

    dir_t dir [14] = '{
        '{3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB},
        '{3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE},
        '{3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF},
        '{3'd1, 64'h80000000, 64'h80000000, 64'h40000000},
        '{3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD},
        '{3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF},
        '{3'd5, 64'd100,      64'd7,        64'd14},
        '{3'd7, 64'd100,      64'd7,        64'd2},
        '{3'd5, 64'd5,        64'd0,        64'hFFFFFFFF},
        '{3'd6, 64'd5,        64'd0,        64'd5},
        '{3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000},
        '{3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0},
        '{3'd0, 64'd3,        64'd4,        64'd12},
        '{3'd1, 64'hFFFFFFFF, 64'd2,        64'hFFFFFFFF}
    };

    function automatic logic [63:0] pick(input int xl);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'd1 << (xl - 1);
            3:       v = 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check1("reset_resp_valid", {63'b0, vld[k]}, 64'd0);
            check1("reset_resp_data", dout[k], 64'd0);
            check1("reset_resp_rd", {59'b0, rdo[k]}, 64'd0);
            check1("reset_busy", {63'b0, bsy[k]}, 64'd0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check1("req_ready_after_reset", {63'b0, rr[k]}, 64'd1);
        for (int k = 0; k < 4; k++) free_at[k] = cyc;

        // Directed vectors, back-to-back, on the three 32-bit instances
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 14; i++) begin
                issue(k, dir[i].f, dir[i].a, dir[i].b, 5'((i * 3) % 32), 1'b1, 1'b1, dir[i].r, acc);
            end
            drain();
        end

        for (int k = 0; k < 3; k++) begin
            // Flush a divide mid-iteration, then a multiply right behind it
            issue(k, 3'd4, 64'd1000, 64'd3, 5'd7, 1'b0, 1'b0, 64'd0, acc);
            while (cyc < acc + 10) @(negedge clk);
            check1("busy_before_flush", {63'b0, bsy[k]}, 64'd1);
            fl[k] = 1'b1;
            @(posedge clk);
            #1 fl[k] = 1'b0;
            check1("busy_after_flush", {63'b0, bsy[k]}, 64'd0);
            free_at[k] = cyc;
            issue(k, 3'd0, 64'd3, 64'd4, 5'd11, 1'b1, 1'b1, 64'd12, acc);
            drain();

            // Flush and request together: nothing accepted
            @(negedge clk);
            funct3 = 3'd0;
            rs1 = 64'd9;
            rs2 = 64'd9;
            rv[k] = 1'b1;
            fl[k] = 1'b1;
            #1 check1("req_ready_during_flush", {63'b0, rr[k]}, 64'd0);
            @(posedge clk);
            #1;
            rv[k] = 1'b0;
            fl[k] = 1'b0;
            check1("flush_blocks_accept_busy", {63'b0, bsy[k]}, 64'd0);
            check1("flush_blocks_accept_valid", {63'b0, vld[k]}, 64'd0);
            free_at[k] = cyc;

            // Flush in the DONE cycle: response still presented that cycle
            issue(k, 3'd0, 64'd5, 64'd6, 5'd21, 1'b1, 1'b1, 64'd30, acc);
            while (cyc < acc + ms_of(k)) @(negedge clk);
            fl[k] = 1'b1;
            #1 check1("req_ready_flush_in_done", {63'b0, rr[k]}, 64'd0);
            @(posedge clk);
            #1 fl[k] = 1'b0;
            check1("idle_after_done_flush", {63'b0, vld[k]}, 64'd0);
            free_at[k] = cyc;
            drain();
        end

        // Asynchronous reset in the middle of a divide
        issue(0, 3'd4, 64'd12345, 64'd17, 5'd3, 1'b0, 1'b0, 64'd0, acc);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check1("async_rst_busy", {63'b0, bsy[0]}, 64'd0);
        check1("async_rst_valid", {63'b0, vld[0]}, 64'd0);
        check1("async_rst_data", dout[0], 64'd0);
        check1("async_rst_rd", {59'b0, rdo[0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check1("req_ready_after_async_rst", {63'b0, rr[0]}, 64'd1);
        for (int k = 0; k < 4; k++) free_at[k] = cyc;
        repeat (40) @(negedge clk);

        // Randomised ops against the reference model, all instances
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [2:0]  f;
                logic [63:0] a, b;
                f = 3'($urandom_range(0, 7));
                a = pick(xl_of(k));
                b = pick(xl_of(k));
                issue(k, f, a, b, 5'($urandom_range(0, 31)), 1'b1, 1'b0, 64'd0, acc);
            end
            drain();
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
